ledmatrix_vram_writer: RTL and testbench
========================================

Name: ledmatrix_vram_writer

Overview:
- Owns the VRAM write port (wrAdd/ramIn/we) of the LED matrix driver.
- Shares that port between two requesters:
  - a host pixel-write interface;
  - an internal rectangle-fill engine (clear screen, solid blocks).
- Arbitration is fixed-priority host with a starvation guard for the fill engine.
- Outputs are registered and connect directly to the driver's write port.

Parameters:
COL_N, 16, matrix columns (power of two)
ROW_N, 16, matrix rows (power of two)
BITS_PER_COL, 4, PWM bits per colour
COLOURS, 3, colour channels per pixel
HOST_BURST, 4, max consecutive host grants while a fill is running (>=1)
Derived: DATA_W=BITS_PER_COL*COLOURS, COL_W=$clog2(COL_N), ROW_W=$clog2(ROW_N), ADD_W=COL_W+ROW_W

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
host_req  in  1  host write request; add/data held stable until acked
host_add  in  ADD_W  pixel address {row,col}
host_data  in  DATA_W  pixel value
host_ack  out  1  combinational grant; write is accepted in this cycle
fill_start  in  1  start rectangle fill (honoured only when idle)
fill_abort  in  1  abandon running fill
fill_x0, fill_x1  in  COL_W  inclusive column range
fill_y0, fill_y1  in  ROW_W  inclusive row range
fill_data  in  DATA_W  fill value
fill_busy  out  1  fill engine in RUN
fill_done  out  1  one-cycle pulse: last fill pixel written
wrAdd  out  ADD_W  VRAM write address
ramIn  out  DATA_W  VRAM write data
we  out  1  VRAM write enable

Behaviour:
- Reset values:
  - we=0, wrAdd=0, ramIn=0, fill_busy=0, fill_done=0.
  - FSM=IDLE, burst counter=0, scan x/y=0.
- Address packing is {row,col}, with row in the MSBs.
- FSM states: IDLE, RUN.
- IDLE:
  - fill_start=1 latches x0/x1/y0/y1/data and sets the scan position to (x0,y0).
  - If x0<=x1 and y0<=y1: go to RUN, fill_busy=1 next cycle.
  - Otherwise (empty rectangle): stay IDLE, pulse fill_done next cycle, no writes.
- RUN:
  - Each fill grant writes one pixel, scanning row-major: x0..x1, then y+1.
  - On the grant of pixel (x1,y1): go to IDLE, fill_busy=0, fill_done=1 on the same edge.
  - fill_start while in RUN is ignored.
  - fill_abort in RUN: go to IDLE on the next edge, with no further fill writes and no fill_done pulse.
  - A write granted in the abort cycle still completes.
- Arbitration, evaluated each cycle:
  - Fill requests whenever the FSM is in RUN.
  - host_ack = host_req & ~(RUN & burst==HOST_BURST).
  - Fill is granted when in RUN and host_ack=0.
- Burst counter:
  - Increments on a host grant while in RUN.
  - Clears on a fill grant or while in IDLE.
- Latency:
  - Grant in cycle N puts we=1 with the matching wrAdd/ramIn in cycle N+1.
  - Back-to-back grants give continuous we.
  - No grant in a cycle gives we=0 in the next cycle.
- Host requester:
  - Presents the next request, or drops host_req, in the cycle after host_ack.
  - host_ack has no combinational dependence on the fill_* inputs.
- Uncontended N-pixel fill, with fill_start in cycle 0:
  - we is high in cycles 2..N+1.
  - fill_busy is high in cycles 1..N.
  - fill_done pulses in cycle N+1.
  - The next fill_start is accepted from cycle N+1.
- rst mid-operation:
  - All state returns to reset values on the reset edge.
  - The in-flight write is dropped (we=0 after reset).
  - No fill_done pulse.
- Width rules:
  - Scan counters are COL_W/ROW_W wide.
  - The end-of-row test compares against x1 before incrementing, so there is no wrap beyond COL_N-1.

Decomposition:
- Package ledmatrix_pkg holds COL_N, ROW_N, BITS_PER_COL, COLOURS, the derived widths, and a pack_addr(row,col) function shared with the display driver.
- One sub-module, fill_rect_scanner, holds the x/y counters, the advance input, and the last-pixel flag.
- The arbiter and FSM stay in the top module.

Test Plan:
1. Host-only write, host_add=0x35, data=0xABC, single request: host_ack in cycle N; we=1, wrAdd=0x35, ramIn=0xABC in N+1; we=0 in N+2.
2. Full-screen fill (0,0)-(15,15), data=0x000, no host traffic: 256 consecutive we cycles with addresses 0x00..0xFF ascending; fill_done in cycle 257; fill_busy low from 257.
3. Fill (2,1)-(4,2) with continuous host_req, HOST_BURST=4: write pattern is host×4, fill×1, repeated; fill addresses 0x12,0x13,0x14,0x22,0x23,0x24; fill_done after the 6th fill write.
4. Empty rectangle x0=5, x1=3: no we from the fill engine; fill_done pulses one cycle after fill_start; fill_busy stays 0.
5. fill_abort after 3 fill writes of a 16-pixel fill: exactly 3 or 4 fill writes total; fill_done never pulses; a new fill_start is accepted the cycle after return to IDLE.
6. rst asserted mid-fill with host_req high: next cycle we=0, fill_busy=0, fill_done=0; after rst deasserts, a host request is acked immediately.

Source files
------------

// File: rtl/ledmatrix_pkg.sv
// Shared geometry and address packing for the LED matrix VRAM path.
// The display driver uses the same pack_addr, so both sides agree on the layout.
package ledmatrix_pkg;

  localparam int COL_N        = 16;
  localparam int ROW_N        = 16;
  localparam int BITS_PER_COL = 4;
  localparam int COLOURS      = 3;

  localparam int DATA_W = BITS_PER_COL * COLOURS;
  localparam int COL_W  = $clog2(COL_N);
  localparam int ROW_W  = $clog2(ROW_N);
  localparam int ADD_W  = COL_W + ROW_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_t;

  // Row occupies the MSBs so a row-major scan gives ascending addresses.
  function automatic logic [ADD_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/fill_rect_scanner.sv
// Row-major x/y walker over an inclusive rectangle; flags the last pixel.
module fill_rect_scanner
  import ledmatrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [COL_W-1:0] x0,
  input  logic [COL_W-1:0] x1,
  input  logic [ROW_W-1:0] y0,
  input  logic [ROW_W-1:0] y1,
  output logic [COL_W-1:0] x,
  output logic [ROW_W-1:0] y,
  output logic             last
);

  logic [COL_W-1:0] x0_r;
  logic [COL_W-1:0] x1_r;
  logic [ROW_W-1:0] y1_r;
  logic [COL_W-1:0] x_r;
  logic [ROW_W-1:0] y_r;

  assign x    = x_r;
  assign y    = y_r;
  assign last = (x_r == x1_r) && (y_r == y1_r);

  // Bounds latch and scan position; end of row is tested before incrementing.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_r <= '0;
      x1_r <= '0;
      y1_r <= '0;
      x_r  <= '0;
      y_r  <= '0;
    end else if (load) begin
      x0_r <= x0;
      x1_r <= x1;
      y1_r <= y1;
      x_r  <= x0;
      y_r  <= y0;
    end else if (advance) begin
      if (x_r == x1_r) begin
        x_r <= x0_r;
        y_r <= y_r + ROW_W'(1);
      end else begin
        x_r <= x_r + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/ledmatrix_vram_writer.sv
// VRAM write-port owner: host pixel writes have priority, the rectangle fill
// engine gets a slot after HOST_BURST consecutive host grants.
module ledmatrix_vram_writer
  import ledmatrix_pkg::*;
#(
  parameter int HOST_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic [ADD_W-1:0]  host_add,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [COL_W-1:0]  fill_x0,
  input  logic [COL_W-1:0]  fill_x1,
  input  logic [ROW_W-1:0]  fill_y0,
  input  logic [ROW_W-1:0]  fill_y1,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADD_W-1:0]  wrAdd,
  output logic [DATA_W-1:0] ramIn,
  output logic              we
);

  localparam int BURST_W = $clog2(HOST_BURST + 1);

  fill_state_t        state_r;
  logic [BURST_W-1:0] burst_r;
  logic [DATA_W-1:0]  data_r;
  logic               run_s;
  logic               fill_grant_s;
  logic               load_s;
  logic [COL_W-1:0]   scan_x_s;
  logic [ROW_W-1:0]   scan_y_s;
  logic               scan_last_s;

  // The grant never looks at fill_* inputs, only at registered state.
  assign run_s        = (state_r == ST_RUN);
  assign host_ack     = host_req & ~(run_s & (burst_r == BURST_W'(HOST_BURST)));
  assign fill_grant_s = run_s & ~host_ack;
  assign load_s       = (state_r == ST_IDLE) & fill_start;

  fill_rect_scanner u_scanner (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .advance (fill_grant_s),
    .x0      (fill_x0),
    .x1      (fill_x1),
    .y0      (fill_y0),
    .y1      (fill_y1),
    .x       (scan_x_s),
    .y       (scan_y_s),
    .last    (scan_last_s)
  );

  // Fill FSM, burst counter and the registered VRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      burst_r   <= '0;
      data_r    <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      we        <= 1'b0;
      wrAdd     <= '0;
      ramIn     <= '0;
    end else begin
      we        <= host_ack | fill_grant_s;
      fill_done <= 1'b0;
      if (host_ack) begin
        wrAdd <= host_add;
        ramIn <= host_data;
      end else if (fill_grant_s) begin
        wrAdd <= pack_addr(scan_y_s, scan_x_s);
        ramIn <= data_r;
      end

      case (state_r)
        ST_IDLE: begin
          burst_r <= '0;
          if (fill_start) begin
            data_r <= fill_data;
            if ((fill_x0 <= fill_x1) && (fill_y0 <= fill_y1)) begin
              state_r   <= ST_RUN;
              fill_busy <= 1'b1;
            end else begin
              fill_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (fill_grant_s) begin
            burst_r <= '0;
          end else if (host_ack) begin
            burst_r <= burst_r + BURST_W'(1);
          end
          // Completion wins over a simultaneous abort: the last pixel was written.
          if (fill_grant_s && scan_last_s) begin
            state_r   <= ST_IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
          end else if (fill_abort) begin
            state_r   <= ST_IDLE;
            fill_busy <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ledmatrix_vram_writer.sv
// Scoreboard bench: expected VRAM writes are queued as stimulus is driven and
// popped by a monitor whenever we is high; per-scenario tasks check timing.
module tb_ledmatrix_vram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req = 1'b0;
  logic [7:0]  host_add = 8'h00;
  logic [11:0] host_data = 12'h000;
  logic        host_ack;
  logic        fill_start = 1'b0;
  logic        fill_abort = 1'b0;
  logic [3:0]  fill_x0 = 4'h0;
  logic [3:0]  fill_x1 = 4'h0;
  logic [3:0]  fill_y0 = 4'h0;
  logic [3:0]  fill_y1 = 4'h0;
  logic [11:0] fill_data = 12'h000;
  logic        fill_busy;
  logic        fill_done;
  logic [7:0]  wrAdd;
  logic [11:0] ramIn;
  logic        we;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  ledmatrix_vram_writer #(.HOST_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_req   (host_req),
    .host_add   (host_add),
    .host_data  (host_data),
    .host_ack   (host_ack),
    .fill_start (fill_start),
    .fill_abort (fill_abort),
    .fill_x0    (fill_x0),
    .fill_x1    (fill_x1),
    .fill_y0    (fill_y0),
    .fill_y1    (fill_y1),
    .fill_data  (fill_data),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .wrAdd      (wrAdd),
    .ramIn      (ramIn),
    .we         (we)
  );

  always #5 clk = ~clk;

  // Every VRAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got add=%h data=%h, required no write", wrAdd, ramIn);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({wrAdd, ramIn} !== e) begin
          errors++;
          $display("FAIL write_content: got add=%h data=%h, required add=%h data=%h",
                   wrAdd, ramIn, e[19:12], e[11:0]);
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_drained(input string name);
    next_cycle();
    sample();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d pending writes, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_fill(input logic [3:0] x0, input logic [3:0] x1,
                          input logic [3:0] y0, input logic [3:0] y1, input logic [11:0] d);
    fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_data = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    sample();
    chk("reset_we", {31'd0, we}, 32'd0);
    chk("reset_wrAdd", {24'd0, wrAdd}, 32'd0);
    chk("reset_ramIn", {20'd0, ramIn}, 32'd0);
    chk("reset_busy", {31'd0, fill_busy}, 32'd0);
    chk("reset_done", {31'd0, fill_done}, 32'd0);
    next_cycle();
    rst = 1'b0;
    sample();
  endtask

  task automatic test_host_write;
    next_cycle();
    host_req = 1'b1; host_add = 8'h35; host_data = 12'hABC;
    exp_q.push_back({8'h35, 12'hABC});
    sample();
    chk("host_ack_n", {31'd0, host_ack}, 32'd1);
    next_cycle();
    host_req = 1'b0;
    sample();
    chk("host_we_n1", {31'd0, we}, 32'd1);
    chk("host_wrAdd_n1", {24'd0, wrAdd}, 32'h35);
    chk("host_ramIn_n1", {20'd0, ramIn}, 32'hABC);
    next_cycle();
    sample();
    chk("host_we_n2", {31'd0, we}, 32'd0);
    check_drained("host_write");
  endtask

  task automatic test_full_fill;
    next_cycle();
    set_fill(4'd0, 4'd15, 4'd0, 4'd15, 12'h000);
    fill_start = 1'b1;
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 12'h000});
    sample();
    for (int c = 1; c <= 258; c++) begin
      next_cycle();
      fill_start = 1'b0;
      sample();
      if (c == 1 || c == 256 || c == 257 || c == 258) begin
        chk($sformatf("full_busy_c%0d", c), {31'd0, fill_busy}, {31'd0, c <= 256});
        chk($sformatf("full_we_c%0d", c), {31'd0, we}, {31'd0, (c >= 2 && c <= 257)});
      end
      if (fill_done !== (c == 257)) begin
        chk($sformatf("full_done_c%0d", c), {31'd0, fill_done}, {31'd0, c == 257});
      end
    end
    chk("full_done_seen", 32'd1, 32'd1 & {31'd0, exp_q.size() == 0});
    check_drained("full_fill");
  endtask

  task automatic test_host_contended;
    int k;
    k = 0;
    exp_q.push_back({8'h80, 12'h500});
    for (int f = 0; f < 6; f++) begin
      for (int h = 1; h <= 4; h++)
        exp_q.push_back({8'h80 + 8'(4 * f + h), 12'h500 + 12'(4 * f + h)});
      if (f < 3) exp_q.push_back({4'h1, 4'h2 + 4'(f), 12'h0F0});
      else       exp_q.push_back({4'h2, 4'h2 + 4'(f - 3), 12'h0F0});
    end
    for (int c = 0; c <= 33; c++) begin
      next_cycle();
      fill_start = (c == 0);
      set_fill(4'd2, 4'd4, 4'd1, 4'd2, 12'h0F0);
      host_req  = (k < 25);
      host_add  = 8'h80 + 8'(k);
      host_data = 12'h500 + 12'(k);
      sample();
      chk($sformatf("cont_ack_c%0d", c), {31'd0, host_ack},
          {31'd0, (k < 25) && (c == 0 || (c % 5) != 0)});
      if (host_ack === 1'b1) k++;
      if (c == 1 || c == 30 || c == 31)
        chk($sformatf("cont_busy_c%0d", c), {31'd0, fill_busy}, {31'd0, c <= 30});
      if (fill_done !== (c == 31))
        chk($sformatf("cont_done_c%0d", c), {31'd0, fill_done}, {31'd0, c == 31});
    end
    host_req = 1'b0;
    check_drained("host_contended");
  endtask

  task automatic test_empty_rect;
    next_cycle();
    set_fill(4'd5, 4'd3, 4'd0, 4'd0, 12'h321);
    fill_start = 1'b1;
    sample();
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      fill_start = 1'b0;
      sample();
      chk($sformatf("empty_done_c%0d", c), {31'd0, fill_done}, {31'd0, c == 1});
      chk($sformatf("empty_busy_c%0d", c), {31'd0, fill_busy}, 32'd0);
      chk($sformatf("empty_we_c%0d", c), {31'd0, we}, 32'd0);
    end
    check_drained("empty_rect");
  endtask

  task automatic test_abort;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 12'h111});
    exp_q.push_back({8'h77, 12'h777});
    for (int c = 0; c <= 9; c++) begin
      next_cycle();
      fill_start = (c == 0 || c == 5);
      fill_abort = (c == 4);
      if (c == 5) set_fill(4'd7, 4'd7, 4'd7, 4'd7, 12'h777);
      else        set_fill(4'd0, 4'd15, 4'd0, 4'd0, 12'h111);
      sample();
      chk($sformatf("abort_busy_c%0d", c), {31'd0, fill_busy},
          {31'd0, (c >= 1 && c <= 4) || c == 6});
      chk($sformatf("abort_we_c%0d", c), {31'd0, we},
          {31'd0, (c >= 2 && c <= 5) || c == 7});
      chk($sformatf("abort_done_c%0d", c), {31'd0, fill_done}, {31'd0, c == 7});
    end
    fill_start = 1'b0;
    fill_abort = 1'b0;
    check_drained("abort");
  endtask

  task automatic test_reset_mid_fill;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 12'hFFF});
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      fill_start = (c == 0);
      set_fill(4'd0, 4'd15, 4'd0, 4'd15, 12'hFFF);
      rst       = (c == 5);
      host_req  = (c == 5 || c == 6);
      host_add  = 8'h5A;
      host_data = 12'h123;
      if (c == 6) exp_q.push_back({8'h5A, 12'h123});
      sample();
      chk($sformatf("rstmid_we_c%0d", c), {31'd0, we}, {31'd0, (c >= 2 && c <= 5) || c == 7});
      if (c >= 6) begin
        chk($sformatf("rstmid_busy_c%0d", c), {31'd0, fill_busy}, 32'd0);
        chk($sformatf("rstmid_done_c%0d", c), {31'd0, fill_done}, 32'd0);
      end
      if (c == 6) chk("rstmid_host_ack", {31'd0, host_ack}, 32'd1);
    end
    check_drained("reset_mid_fill");
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_full_fill();
    test_host_contended();
    test_empty_rect();
    test_abort();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
